// File: rtl/gsm_sym_source_upsampler_pkg.sv
// rtl/gsm_sym_source_upsampler_pkg.sv - shared constants, Gray level table and FSM states
package gsm_sym_source_upsampler_pkg;

    localparam int GSM_WIDTH = 18;
    localparam int GSM_OSR   = 4;
    localparam int GSM_UPS   = 4;
    localparam int LFSR_LEN  = 22;

    localparam logic [LFSR_LEN-1:0]         GSM_SEED    = 22'h1;
    localparam logic signed [GSM_WIDTH-1:0] GSM_LVL_A   = 18'sd32768;
    localparam logic signed [GSM_WIDTH-1:0] GSM_IMP_AMP = 18'sd131071;

    // Level multiplier of LVL_A indexed by Gray bits {b1,b0}
    localparam int GRAY_MULT [4] = '{-3, -1, 3, 1};

    typedef enum logic [1:0] {
        ST_PN,
        ST_IMP_ARM,
        ST_IMP_DONE
    } imp_state_t;

endpackage

// File: rtl/gsm_sym_source_upsampler_if.sv
// rtl/gsm_sym_source_upsampler_if.sv - control inputs and sample/strobe outputs of the source
interface gsm_sym_source_upsampler_if #(
    parameter int WIDTH = 18
);
    logic                    run;
    logic                    mode;
    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic [1:0]              sym_phase;
    logic [1:0]              sym_bits;
    logic signed [WIDTH-1:0] x_out;

    modport master (
        input  run, mode,
        output sam_clk_en, sym_clk_en, sym_phase, sym_bits, x_out
    );

    modport slave (
        output run, mode,
        input  sam_clk_en, sym_clk_en, sym_phase, sym_bits, x_out
    );
endinterface

// File: rtl/gsm_lfsr22.sv
// rtl/gsm_lfsr22.sv - x^22+x^21+1 Fibonacci LFSR, two shifts per step, zero-lock reload
module gsm_lfsr22
    import gsm_sym_source_upsampler_pkg::*;
#(
    parameter logic [LFSR_LEN-1:0] SEED = GSM_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [1:0] bits
);
    localparam logic [LFSR_LEN-1:0] SEED_EFF = (SEED == '0) ? 22'h1 : SEED;

    logic [LFSR_LEN-1:0] s;

    // b1 is s[21] before the first shift, b0 is s[21] before the second, which is s[20] now
    assign bits = s[21:20];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s <= SEED_EFF;
        end else if (step) begin
            s <= (s == '0) ? SEED_EFF : {s[19:0], s[21] ^ s[20], s[20] ^ s[19]};
        end
    end
endmodule

// File: rtl/gsm_sym_source_upsampler.sv
// rtl/gsm_sym_source_upsampler.sv - sample/symbol strobes, PN 4-ASK mapper, impulse mode, zero stuffing
module gsm_sym_source_upsampler
    import gsm_sym_source_upsampler_pkg::*;
#(
    parameter int                        WIDTH   = GSM_WIDTH,
    parameter int                        OSR     = GSM_OSR,
    parameter int                        UPS     = GSM_UPS,
    parameter logic [LFSR_LEN-1:0]       SEED    = GSM_SEED,
    parameter logic signed [WIDTH-1:0]   LVL_A   = GSM_LVL_A,
    parameter logic signed [WIDTH-1:0]   IMP_AMP = GSM_IMP_AMP
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    gsm_sym_source_upsampler_if.master    bus
);
    localparam int CW = $clog2(OSR);

    logic [CW-1:0]           clk_cnt;
    logic [1:0]              lfsr_bits;
    logic                    pn_step;
    logic signed [WIDTH-1:0] pn_level;
    imp_state_t              imp_state;

    assign pn_step  = bus.sam_clk_en && bus.sym_clk_en && !bus.mode;
    assign pn_level = WIDTH'(GRAY_MULT[lfsr_bits] * LVL_A);

    gsm_lfsr22 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (sys_clk),
        .reset (reset),
        .step  (pn_step),
        .bits  (lfsr_bits)
    );

    // Strobes are registered one count early so they are high exactly while clk_cnt==OSR-1;
    // all sample-side state moves on the edge that closes a strobe cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            clk_cnt        <= '0;
            bus.sam_clk_en <= 1'b0;
            bus.sym_clk_en <= 1'b0;
            bus.sym_phase  <= '0;
            bus.sym_bits   <= '0;
            bus.x_out      <= '0;
            imp_state      <= ST_PN;
        end else begin
            if (bus.run) begin
                clk_cnt <= (clk_cnt == CW'(OSR - 1)) ? '0 : clk_cnt + 1'b1;
            end
            bus.sam_clk_en <= bus.run && (clk_cnt == CW'(OSR - 2));
            bus.sym_clk_en <= bus.run && (clk_cnt == CW'(OSR - 2)) && (bus.sym_phase == 2'(UPS - 1));

            if (bus.sam_clk_en) begin
                bus.sym_phase <= (bus.sym_phase == 2'(UPS - 1)) ? 2'd0 : bus.sym_phase + 2'd1;
                if (bus.mode) begin
                    bus.x_out <= (imp_state == ST_IMP_DONE) ? '0 : IMP_AMP;
                    imp_state <= ST_IMP_DONE;
                end else if (bus.sym_clk_en) begin
                    bus.x_out    <= pn_level;
                    bus.sym_bits <= lfsr_bits;
                    imp_state    <= ST_PN;
                end else begin
                    // After an impulse, PN output waits for the next symbol boundary
                    bus.x_out <= '0;
                    if (imp_state == ST_IMP_DONE) begin
                        imp_state <= ST_IMP_ARM;
                    end
                end
            end
        end
    end
endmodule
